// File: rtl/orb_desc_serializer_if.sv
// orb_desc_serializer_if: descriptor strobe input and word-stream output bundle
interface orb_desc_serializer_if #(
  parameter int WIDTH_DESCRIPTORS = 256,
  parameter int WIDTH_OUT = 8,
  parameter int FIFO_DEPTH = 4
);
  logic in_valid;
  logic [WIDTH_DESCRIPTORS-1:0] descriptors;
  logic [WIDTH_OUT-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [15:0] drop_count;
  modport master (
    output in_valid, descriptors, out_ready,
    input out_data, out_valid, out_last, fifo_level, drop_count
  );
  modport slave (
    input in_valid, descriptors, out_ready,
    output out_data, out_valid, out_last, fifo_level, drop_count
  );
endinterface

// File: rtl/orb_desc_serializer.sv
// orb_desc_serializer: buffers descriptor strobes in a small FIFO and streams them MSB word first
module orb_desc_serializer #(
  parameter int WIDTH_DESCRIPTORS = 256,
  parameter int WIDTH_OUT = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  orb_desc_serializer_if.slave bus
);
  localparam int N = WIDTH_DESCRIPTORS / WIDTH_OUT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_state_nx;
  logic [WIDTH_DESCRIPTORS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic [WIDTH_DESCRIPTORS-1:0] r_shift;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic r_last;
  logic [15:0] r_drops;
  logic w_xfer, w_end, w_empty, w_full, w_pop, w_wr, w_drop;
  always_comb begin
    w_empty = r_count == '0;
    w_full = r_count == (AW+1)'(FIFO_DEPTH);
    w_xfer = r_state == SEND && bus.out_ready;
    w_end = w_xfer && r_cnt == CW'(N-1);
    w_pop = !w_empty && (r_state == IDLE || w_end);
    w_wr = bus.in_valid && (!w_full || w_pop);
    w_drop = bus.in_valid && !w_wr;
    w_state_nx = w_pop ? SEND : w_end ? IDLE : r_state;
    w_cnt_nx = w_pop ? '0 : w_xfer ? r_cnt + 1'b1 : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_shift <= '0;
      r_cnt <= '0;
      r_last <= 1'b0;
      r_drops <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_last <= w_state_nx == SEND && w_cnt_nx == CW'(N-1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_pop) r_shift <= r_mem[r_rd_ptr];
      else if (w_xfer) r_shift <= r_shift << WIDTH_OUT;
      if (w_drop && r_drops != '1) r_drops <= r_drops + 1'b1;
    end
  end
  // storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) if (w_wr) r_mem[r_wr_ptr] <= bus.descriptors;
  assign bus.out_data = r_shift[WIDTH_DESCRIPTORS-1 -: WIDTH_OUT];
  assign bus.out_valid = r_state == SEND;
  assign bus.out_last = r_last;
  assign bus.fifo_level = r_count;
  assign bus.drop_count = r_drops;
endmodule

// File: tb/tb_orb_desc_serializer.sv
// tb_orb_desc_serializer: scenario tasks plus randomized run against a queue-based reference model
module tb_orb_desc_serializer;
  localparam int WD = 256;
  localparam int WO = 8;
  localparam int DEPTH = 4;
  localparam int N = WD / WO;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  orb_desc_serializer_if #(.WIDTH_DESCRIPTORS(WD), .WIDTH_OUT(WO), .FIFO_DEPTH(DEPTH)) bus ();
  orb_desc_serializer #(.WIDTH_DESCRIPTORS(WD), .WIDTH_OUT(WO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int total = 0;
  int bad = 0;
  logic [WD-1:0] m_q[$];
  logic [WD-1:0] m_cur;
  int m_idx;
  bit m_busy;
  int m_drops;

  function automatic logic [WO-1:0] word_of(input logic [WD-1:0] d, input int i);
    return WO'(d >> (WD - WO * (i + 1)));
  endfunction

  function automatic logic [WD-1:0] rand_desc();
    logic [WD-1:0] d;
    for (int i = 0; i < WD / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [WD-1:0] seq_desc();
    logic [WD-1:0] d;
    for (int i = 0; i < N; i++) d[WD-1-WO*i -: WO] = WO'(i);
    return d;
  endfunction

  // drive one cycle, advance the model by the same edge, then settle past the edge
  task automatic step(input bit r, input bit iv, input logic [WD-1:0] d, input bit rdy);
    bit xfer, endw, pop, full;
    rst = r;
    bus.in_valid = iv;
    bus.descriptors = d;
    bus.out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_busy = 0;
      m_idx = 0;
      m_drops = 0;
    end else begin
      xfer = m_busy && rdy;
      endw = xfer && m_idx == N - 1;
      pop = m_q.size() > 0 && (!m_busy || endw);
      full = m_q.size() == DEPTH;
      if (pop) begin
        m_cur = m_q.pop_front();
        m_idx = 0;
        m_busy = 1;
      end else if (endw) m_busy = 0;
      else if (xfer) m_idx++;
      if (iv) begin
        if (!full || pop) m_q.push_back(d);
        else if (m_drops < 65535) m_drops++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, '0, 0);
    step(1, 1, rand_desc(), 1);
    total++;
    if ({bus.out_data, bus.out_valid, bus.out_last, bus.fifo_level, bus.drop_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got data=%h v=%b l=%b lvl=%0d drop=%0d exp all 0",
               bus.out_data, bus.out_valid, bus.out_last, bus.fifo_level, bus.drop_count);
    end
  endtask

  task automatic test_single();
    logic [WD-1:0] d;
    d = seq_desc();
    step(1, 0, '0, 1);
    step(0, 1, d, 1);
    total++;
    if (bus.fifo_level !== 3'd1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_latency got lvl=%0d v=%b exp lvl=1 v=0", bus.fifo_level, bus.out_valid);
    end
    step(0, 0, '0, 1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== WO'(i) || bus.out_last !== (i == N - 1)) begin
        bad++;
        $display("FAIL single_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 i, bus.out_valid, bus.out_data, bus.out_last, WO'(i), i == N - 1);
      end
      step(0, 0, '0, 1);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL single_end got v=%b lvl=%0d exp v=0 lvl=0", bus.out_valid, bus.fifo_level);
    end
  endtask

  task automatic test_backpressure();
    logic [WD-1:0] d;
    logic [WO-1:0] got[$];
    logic [WO-1:0] pd;
    bit pv, pr, pl, rdy;
    int c, errs;
    d = seq_desc();
    pv = 0; pr = 0; pl = 0; pd = '0; c = 0; errs = 0;
    step(1, 0, '0, 0);
    step(0, 1, d, 0);
    while (got.size() < N && c < 300) begin
      rdy = (c % 3 == 0);
      if (pv && !pr) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.out_last !== pl) begin
          bad++;
          $display("FAIL bp_hold c=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   c, bus.out_valid, bus.out_data, bus.out_last, pd, pl);
        end
      end
      if (bus.out_valid && rdy) got.push_back(bus.out_data);
      pv = bus.out_valid; pr = rdy; pd = bus.out_data; pl = bus.out_last;
      step(0, 0, '0, rdy);
      c++;
    end
    step(0, 0, '0, 1);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_extra got v=%b exp v=0", bus.out_valid);
    end
    for (int i = 0; i < got.size(); i++) if (got[i] !== WO'(i)) errs++;
    total++;
    if (got.size() != N || errs != 0) begin
      bad++;
      $display("FAIL bp_stream got count=%0d wrong=%0d exp count=%0d wrong=0", got.size(), errs, N);
    end
  endtask

  task automatic test_overflow();
    logic [WD-1:0] d[6];
    logic [WO-1:0] got[$];
    int lasts, errs, c;
    lasts = 0; errs = 0; c = 0;
    step(1, 0, '0, 0);
    for (int k = 0; k < 6; k++) begin
      d[k] = rand_desc();
      step(0, 1, d[k], 0);
    end
    total++;
    if (bus.fifo_level !== 3'd4 || bus.drop_count !== 16'd1 || bus.out_valid !== 1'b1 ||
        bus.out_data !== word_of(d[0], 0)) begin
      bad++;
      $display("FAIL ovf_state got lvl=%0d drop=%0d v=%b d=%h exp lvl=4 drop=1 v=1 d=%h",
               bus.fifo_level, bus.drop_count, bus.out_valid, bus.out_data, word_of(d[0], 0));
    end
    while (got.size() < 5 * N && c < 400) begin
      if (bus.out_valid) got.push_back(bus.out_data);
      if (bus.out_valid && bus.out_last) lasts++;
      step(0, 0, '0, 1);
      c++;
    end
    for (int i = 0; i < got.size(); i++) if (got[i] !== word_of(d[i / N], i % N)) errs++;
    total++;
    if (got.size() != 5 * N || errs != 0 || lasts != 5 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_drain got words=%0d wrong=%0d lasts=%0d v=%b exp words=%0d wrong=0 lasts=5 v=0",
               got.size(), errs, lasts, bus.out_valid, 5 * N);
    end
  endtask

  task automatic test_same_cycle();
    logic [WD-1:0] d[6];
    int c;
    c = 0;
    step(1, 0, '0, 0);
    for (int k = 0; k < 6; k++) d[k] = rand_desc();
    for (int k = 0; k < 5; k++) step(0, 1, d[k], 0);
    while (!(bus.out_valid && bus.out_last) && c < 64) begin
      step(0, 0, '0, 1);
      c++;
    end
    total++;
    if (!(bus.out_valid && bus.out_last)) begin
      bad++;
      $display("FAIL same_wait got no last word within %0d cycles exp last word", c);
    end
    step(0, 1, d[5], 1);
    total++;
    if (bus.fifo_level !== 3'd4 || bus.drop_count !== 16'd0 || bus.out_valid !== 1'b1 ||
        bus.out_data !== word_of(d[1], 0) || bus.out_last !== 1'b0) begin
      bad++;
      $display("FAIL same_pop_write got lvl=%0d drop=%0d v=%b d=%h l=%b exp lvl=4 drop=0 v=1 d=%h l=0",
               bus.fifo_level, bus.drop_count, bus.out_valid, bus.out_data, bus.out_last, word_of(d[1], 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [WD-1:0] a, b;
    a = rand_desc();
    b = rand_desc();
    step(1, 0, '0, 0);
    step(0, 1, a, 0);
    step(0, 1, b, 0);
    for (int i = 0; i < 2 * N; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== word_of(i < N ? a : b, i % N) ||
          bus.out_last !== (i % N == N - 1)) begin
        bad++;
        $display("FAIL b2b_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, bus.out_valid,
                 bus.out_data, bus.out_last, word_of(i < N ? a : b, i % N), i % N == N - 1);
      end
      step(0, 0, '0, 1);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got v=%b exp v=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [WD-1:0] e;
    e = rand_desc();
    step(1, 0, '0, 0);
    for (int k = 0; k < 6; k++) step(0, 1, rand_desc(), 0);
    for (int k = 0; k < 10; k++) step(0, 0, '0, 1);
    total++;
    if (bus.drop_count !== 16'd1 || bus.out_last !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got drop=%0d v=%b l=%b exp drop=1 v=1 l=0", bus.drop_count, bus.out_valid, bus.out_last);
    end
    step(1, 1, rand_desc(), 1);
    total++;
    if ({bus.out_data, bus.out_valid, bus.out_last, bus.fifo_level, bus.drop_count} !== '0) begin
      bad++;
      $display("FAIL mid_reset got data=%h v=%b l=%b lvl=%0d drop=%0d exp all 0",
               bus.out_data, bus.out_valid, bus.out_last, bus.fifo_level, bus.drop_count);
    end
    step(0, 1, e, 1);
    step(0, 0, '0, 1);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== word_of(e, 0) || bus.drop_count !== 16'd0 ||
        bus.fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL mid_restart got v=%b d=%h drop=%0d lvl=%0d exp v=1 d=%h drop=0 lvl=0",
               bus.out_valid, bus.out_data, bus.drop_count, bus.fifo_level, word_of(e, 0));
    end
  endtask

  task automatic test_random();
    bit iv, rdy, r;
    int pct;
    step(1, 0, '0, 0);
    for (int c = 0; c < 3000; c++) begin
      pct = ((c / 500) % 2 == 1) ? 20 : 3;
      iv = $urandom_range(0, 99) < pct;
      rdy = $urandom_range(0, 99) < 70;
      r = $urandom_range(0, 999) == 0;
      step(r, iv, rand_desc(), rdy);
      total++;
      if (bus.out_valid !== m_busy || bus.out_last !== (m_busy && m_idx == N - 1) ||
          bus.fifo_level !== 3'(m_q.size()) || bus.drop_count !== 16'(m_drops)) begin
        bad++;
        $display("FAIL rand_ctrl c=%0d got v=%b l=%b lvl=%0d drop=%0d exp v=%b l=%b lvl=%0d drop=%0d",
                 c, bus.out_valid, bus.out_last, bus.fifo_level, bus.drop_count,
                 m_busy, m_busy && m_idx == N - 1, m_q.size(), m_drops);
      end
      if (m_busy) begin
        total++;
        if (bus.out_data !== word_of(m_cur, m_idx)) begin
          bad++;
          $display("FAIL rand_data c=%0d got %h exp %h", c, bus.out_data, word_of(m_cur, m_idx));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.descriptors = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
